// File: rtl/neighbor_halo_link.sv
// Halo-exchange link: FIFO-buffered tile-to-tile stream with ordered end-of-exchange.
// Optional transfer counter enabled by NEIGHBOR_LINK_STATS_EN.
module neighbor_halo_link #(
  parameter int TILE_SIZE   = 128,
  parameter int FIFO_DEPTH  = 8,
  parameter int STATS_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   src_value,
  input  logic [$clog2(TILE_SIZE)-1:0] src_row,
  input  logic [$clog2(TILE_SIZE)-1:0] src_column,
  input  logic                         src_write_enable,
  input  logic                         src_exchange_done,
  output logic                         src_ready,
  input  logic                         dst_clear_to_send,
  output logic [7:0]                   dst_value,
  output logic [$clog2(TILE_SIZE)-1:0] dst_row,
  output logic [$clog2(TILE_SIZE)-1:0] dst_column,
  output logic                         dst_write_enable,
  output logic                         dst_exchange_done,
  input  logic                         cycle_done,
  output logic                         overflow
`ifdef NEIGHBOR_LINK_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]       transfer_count
`endif
);

  localparam int CW   = $clog2(TILE_SIZE);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = 8 + 2 * CW;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || STATS_WIDTH < 1) begin : g_bad_param
    $error("neighbor_halo_link: bad parameter");
  end

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [7:0]      val_q, val_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            we_q, we_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;
  logic [EW-1:0]   head;

  assign src_ready = (state_q == STREAM) && (count_q < DEPTH_C);
  assign push      = src_write_enable && src_ready;
  assign pop       = (count_q != '0) && dst_clear_to_send;
  assign head      = mem_q[rptr_q];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    val_d   = val_q;
    row_d   = row_q;
    col_d   = col_q;
    we_d    = pop;
    ovf_d   = ovf_q | (src_write_enable & ~src_ready);
    unique case (state_q)
      STREAM:  if (src_exchange_done) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = STREAM;
    endcase
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      {val_d, row_d, col_d} = head;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Layer rearm wins over everything; delivered data regs keep last value
    if (cycle_done) begin
      state_d = STREAM;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      we_d    = 1'b0;
      ovf_d   = 1'b0;
      val_d   = val_q;
      row_d   = row_q;
      col_d   = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= STREAM;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      val_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      val_q   <= val_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !cycle_done && reset_n)
      mem_q[wptr_q] <= {src_value, src_row, src_column};
  end

  assign dst_value         = val_q;
  assign dst_row           = row_q;
  assign dst_column        = col_q;
  assign dst_write_enable  = we_q;
  assign dst_exchange_done = (state_q == DONE);
  assign overflow          = ovf_q;

`ifdef NEIGHBOR_LINK_STATS_EN
  logic [STATS_WIDTH-1:0] tc_q, tc_d;

  always_comb begin
    tc_d = tc_q;
    if (we_q && (tc_q != '1)) tc_d = tc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tc_q <= '0;
    else          tc_q <= tc_d;
  end

  assign transfer_count = tc_q;
`endif

endmodule

// File: tb/tb_neighbor_halo_link.sv
// Directed testbench for neighbor_halo_link.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_neighbor_halo_link;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] src_value;
  logic [6:0] src_row, src_column;
  logic       src_write_enable, src_exchange_done, src_ready;
  logic       dst_clear_to_send;
  logic [7:0] dst_value;
  logic [6:0] dst_row, dst_column;
  logic       dst_write_enable, dst_exchange_done;
  logic       cycle_done, overflow;
`ifdef NEIGHBOR_LINK_STATS_EN
  logic [15:0] transfer_count;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  neighbor_halo_link dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .src_value         (src_value),
    .src_row           (src_row),
    .src_column        (src_column),
    .src_write_enable  (src_write_enable),
    .src_exchange_done (src_exchange_done),
    .src_ready         (src_ready),
    .dst_clear_to_send (dst_clear_to_send),
    .dst_value         (dst_value),
    .dst_row           (dst_row),
    .dst_column        (dst_column),
    .dst_write_enable  (dst_write_enable),
    .dst_exchange_done (dst_exchange_done),
    .cycle_done        (cycle_done),
    .overflow          (overflow)
`ifdef NEIGHBOR_LINK_STATS_EN
    ,
    .transfer_count    (transfer_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic cts);
    reset_n           = 1'b1;
    src_value         = 8'h00;
    src_row           = 7'd0;
    src_column        = 7'd0;
    src_write_enable  = 1'b0;
    src_exchange_done = 1'b0;
    dst_clear_to_send = cts;
    cycle_done        = 1'b0;
  endtask

  task automatic drive_push(input logic [7:0] v, input logic [6:0] r,
                            input logic [6:0] c);
    src_value        = v;
    src_row          = r;
    src_column       = c;
    src_write_enable = 1'b1;
  endtask

  task automatic rearm();
    idle(1'b0);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_value         = 8'($urandom);
      src_row           = 7'($urandom);
      src_column        = 7'($urandom);
      src_write_enable  = 1'($urandom);
      src_exchange_done = 1'($urandom);
      dst_clear_to_send = 1'($urandom);
      cycle_done        = 1'($urandom);
      tick();
    end
    nvec++;
    if ({dst_value, dst_row, dst_column} !== 22'd0) begin
      nerr++;
      $display("FAIL reset_data got %h/%h/%h want 0/0/0",
               dst_value, dst_row, dst_column);
    end
    nvec++;
    if ({dst_write_enable, dst_exchange_done, overflow} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags got we/done/ovf=%b%b%b want 000",
               dst_write_enable, dst_exchange_done, overflow);
    end
`ifdef NEIGHBOR_LINK_STATS_EN
    nvec++;
    if (transfer_count !== 16'd0) begin
      nerr++;
      $display("FAIL reset_tcount got %0d want 0", transfer_count);
    end
`endif
    idle(1'b0);
    tick();
    nvec++;
    if (src_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready got %b want 1", src_ready);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] v [3];
    logic [6:0] r [3];
    logic [6:0] c [3];
    v = '{8'h11, 8'h22, 8'h33};
    r = '{7'd1, 7'd2, 7'd3};
    c = '{7'd9, 7'd10, 7'd11};
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (i < 3) drive_push(v[i], r[i], c[i]);
      nvec++;
      if (dst_write_enable !== (i >= 2 && i < 5)) begin
        nerr++;
        $display("FAIL stream_we[%0d] got %b want %b", i,
                 dst_write_enable, (i >= 2 && i < 5));
      end
      if (i >= 2 && i < 5) begin
        nvec++;
        if ({dst_value, dst_row, dst_column} !== {v[i-2], r[i-2], c[i-2]}) begin
          nerr++;
          $display("FAIL stream_data[%0d] got %h/%0d/%0d want %h/%0d/%0d",
                   i, dst_value, dst_row, dst_column,
                   v[i-2], r[i-2], c[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 9; i++) begin
      idle(1'b0);
      drive_push(8'h40 + 8'(i), 7'(i), 7'(2 * i));
      nvec++;
      if (src_ready !== (i < 8)) begin
        nerr++;
        $display("FAIL full_ready[%0d] got %b want %b", i, src_ready, (i < 8));
      end
      tick();
    end
    idle(1'b1);
    nvec++;
    if (overflow !== 1'b1) begin
      nerr++;
      $display("FAIL full_overflow got %b want 1", overflow);
    end
    for (int j = 0; j < 10; j++) begin
      idle(1'b1);
      nvec++;
      if (dst_write_enable !== (j >= 1 && j <= 8)) begin
        nerr++;
        $display("FAIL full_we[%0d] got %b want %b", j,
                 dst_write_enable, (j >= 1 && j <= 8));
      end
      if (j >= 1 && j <= 8) begin
        nvec++;
        if ({dst_value, dst_row, dst_column} !==
            {8'h40 + 8'(j - 1), 7'(j - 1), 7'(2 * (j - 1))}) begin
          nerr++;
          $display("FAIL full_data[%0d] got %h/%0d/%0d want %h/%0d/%0d",
                   j, dst_value, dst_row, dst_column,
                   8'h40 + 8'(j - 1), j - 1, 2 * (j - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_done_ordering();
    rearm();
    nvec++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL rearm_overflow got %b want 0", overflow);
    end
    idle(1'b0);
    drive_push(8'hA1, 7'd5, 7'd6);
    tick();
    idle(1'b0);
    drive_push(8'hA2, 7'd7, 7'd8);
    tick();
    idle(1'b0);
    src_exchange_done = 1'b1;
    tick();
    idle(1'b0);
    tick();
    tick();
    nvec++;
    if ({dst_exchange_done, src_ready} !== 2'b00) begin
      nerr++;
      $display("FAIL drain_hold got done/ready=%b%b want 00",
               dst_exchange_done, src_ready);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      nvec++;
      if ({dst_write_enable, dst_exchange_done} !==
          {(k == 1 || k == 2), (k == 3)}) begin
        nerr++;
        $display("FAIL done_seq[%0d] got we/done=%b%b want %b%b", k,
                 dst_write_enable, dst_exchange_done,
                 (k == 1 || k == 2), (k == 3));
      end
      if (k == 1 || k == 2) begin
        nvec++;
        if (dst_value !== ((k == 1) ? 8'hA1 : 8'hA2)) begin
          nerr++;
          $display("FAIL done_data[%0d] got %h want %h", k, dst_value,
                   (k == 1) ? 8'hA1 : 8'hA2);
        end
      end
      tick();
    end
    idle(1'b1);
    drive_push(8'hEE, 7'd1, 7'd1);
    tick();
    idle(1'b1);
    nvec++;
    if ({overflow, dst_exchange_done, dst_write_enable} !== 3'b110) begin
      nerr++;
      $display("FAIL done_write got ovf/done/we=%b%b%b want 110",
               overflow, dst_exchange_done, dst_write_enable);
    end
    rearm();
    nvec++;
    if ({dst_exchange_done, overflow, dst_write_enable, src_ready} !== 4'b0001) begin
      nerr++;
      $display("FAIL cycle_done got done/ovf/we/ready=%b%b%b%b want 0001",
               dst_exchange_done, overflow, dst_write_enable, src_ready);
    end
  endtask

  task automatic test_done_latency();
    idle(1'b1);
    src_exchange_done = 1'b1;
    tick();
    idle(1'b1);
    nvec++;
    if (dst_exchange_done !== 1'b0) begin
      nerr++;
      $display("FAIL done_lat_n1 got %b want 0", dst_exchange_done);
    end
    tick();
    nvec++;
    if (dst_exchange_done !== 1'b1) begin
      nerr++;
      $display("FAIL done_lat_n2 got %b want 1", dst_exchange_done);
    end
    rearm();
  endtask

  task automatic test_mid_drain_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      drive_push(8'h70 + 8'(i), 7'(i), 7'(i));
      tick();
    end
    idle(1'b0);
    src_exchange_done = 1'b1;
    tick();
    idle(1'b1);
    reset_n = 1'b0;
    tick();
    idle(1'b1);
    nvec++;
    if ({dst_write_enable, dst_exchange_done, overflow, src_ready,
         dst_value} !== {4'b0001, 8'h00}) begin
      nerr++;
      $display("FAIL mdr_state got we/done/ovf/ready=%b%b%b%b val=%h want 0001 00",
               dst_write_enable, dst_exchange_done, overflow, src_ready,
               dst_value);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if ({dst_write_enable, dst_exchange_done} !== 2'b00) begin
        nerr++;
        $display("FAIL mdr_quiet[%0d] got we/done=%b%b want 00", i,
                 dst_write_enable, dst_exchange_done);
      end
    end
  endtask

  task automatic test_stats();
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (i < 5) drive_push(8'h90 + 8'(i), 7'(i), 7'(i));
      if (dst_write_enable === 1'b1) seen++;
      tick();
    end
    nvec++;
    if (seen !== 5) begin
      nerr++;
      $display("FAIL stats_deliveries got %0d want 5", seen);
    end
    rearm();
`ifdef NEIGHBOR_LINK_STATS_EN
    nvec++;
    if (transfer_count !== 16'd5) begin
      nerr++;
      $display("FAIL stats_count got %0d want 5", transfer_count);
    end
    idle(1'b1);
    tick();
    tick();
    tick();
    nvec++;
    if (transfer_count !== 16'd5) begin
      nerr++;
      $display("FAIL stats_hold got %0d want 5", transfer_count);
    end
`endif
  endtask

  initial begin
    idle(1'b0);
    test_reset();
    test_streaming();
    test_full_overflow();
    test_done_ordering();
    test_done_latency();
    test_mid_drain_reset();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/neighbor_halo_link.md
# neighbor_halo_link

Unidirectional halo-exchange link between two adjacent tiles. It consumes the halo stream that one tile's `ppu` emits on its `neighbor_output_*` / `exchange_done` ports and delivers it to the adjacent tile's `ppu` `neighbor_input_*` / `neighbor_exchange_done` ports. A small FIFO absorbs bursts while the destination withholds `clear_to_send`. End-of-exchange is forwarded only after every buffered entry has been delivered. Eight instances per tile (one per neighbor direction) sit between the `ppu` array and the top level.

## Interface
Parameters:
- `TILE_SIZE`, 128: tile dimension; coordinate width is `$clog2(TILE_SIZE)`.
- `FIFO_DEPTH`, 8: entries buffered; power of two, ≥2.
- `STATS_WIDTH`, 16: width of the transfer counter (only with the stats macro).

Ports (clock and reset first). One clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `src_value`  in  8  halo activation from the source `ppu`.
- `src_row`  in  `$clog2(TILE_SIZE)`  destination-tile row.
- `src_column`  in  `$clog2(TILE_SIZE)`  destination-tile column.
- `src_write_enable`  in  1  entry valid this cycle.
- `src_exchange_done`  in  1  single-cycle pulse: source halo stream complete.
- `src_ready`  out  1  FIFO can accept an entry this cycle.
- `dst_clear_to_send`  in  1  destination accepts entries.
- `dst_value`  out  8  delivered activation (registered).
- `dst_row`, `dst_column`  out  `$clog2(TILE_SIZE)`  delivered coordinates (registered).
- `dst_write_enable`  out  1  delivered entry valid (registered).
- `dst_exchange_done`  out  1  level; all halo data delivered.
- `cycle_done`  in  1  pulse: layer cycle finished; rearms the link.
- `overflow`  out  1  sticky protocol-error flag.
- `transfer_count`  out  `STATS_WIDTH`  present only with `NEIGHBOR_LINK_STATS_EN`.

## Operation
- FSM states: STREAM (reset state), DRAIN, DONE.
- Push:
  - An entry is accepted when `src_write_enable` and `src_ready` are both high in STREAM.
  - `src_ready` = (state==STREAM) && (count < FIFO_DEPTH), where count is the value at the start of the cycle. A pop in the same cycle does not free a slot for a push in that cycle.
  - A write while `src_ready`=0 (full, DRAIN or DONE) is dropped and sets `overflow`.
- Pop:
  - When count>0 and `dst_clear_to_send`=1, the head is popped and loaded into the `dst_*` registers, and `dst_write_enable`=1 in the next cycle.
  - Otherwise `dst_write_enable`=0 next cycle; `dst_value`/`dst_row`/`dst_column` hold their last values.
  - At most one pop per cycle. Entries are delivered in FIFO order.
- Simultaneous push and pop when 0<count<FIFO_DEPTH: count is unchanged and both take effect.
- STREAM→DRAIN on `src_exchange_done`. A push in the same cycle is still accepted.
- DRAIN→DONE when count==0 at the start of the cycle. `dst_exchange_done`=1 from the following cycle, so it is never high before or during the last `dst_write_enable`.
- `src_exchange_done` in DRAIN or DONE is ignored.
- `cycle_done` in any state:
  - next state STREAM; FIFO flushed (count=0).
  - `dst_exchange_done`=0 and `dst_write_enable`=0 next cycle.
  - `overflow` cleared.
  - `cycle_done` has priority over every other event.
- Count arithmetic: `$clog2(FIFO_DEPTH)+1` bits. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: state STREAM, count 0, `dst_value`=0, `dst_row`=0, `dst_column`=0, `dst_write_enable`=0, `dst_exchange_done`=0, `overflow`=0, `transfer_count`=0. `src_ready`=1 the cycle after reset is released.
- Latency: an entry pushed in cycle N with `dst_clear_to_send` held high appears with `dst_write_enable`=1 in cycle N+2.
- Throughput: one entry per cycle sustained.
- Exchange done: after `src_exchange_done` in cycle N with an empty FIFO, `dst_exchange_done`=1 in cycle N+2.
- Reset asserted mid-operation: all buffered entries are discarded, and every output takes its reset value in the next cycle.

## Configuration
- `NEIGHBOR_LINK_STATS_EN` defined:
  - `transfer_count` port and register exist.
  - The counter increments on every cycle with `dst_write_enable`=1 and saturates at all-ones.
  - Cleared by reset only, not by `cycle_done`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with random inputs → all outputs at reset values; `src_ready`=1 after release.
- Streaming: `dst_clear_to_send`=1; push (0x11,r1,c1), (0x22,r2,c2), (0x33,r3,c3) in cycles 0–2 → `dst_write_enable`=1 in cycles 2–4 carrying the same entries in order.
- Full/overflow: `dst_clear_to_send`=0; push 9 entries back-to-back.
  - `src_ready`=0 after the 8th; the 9th is dropped; `overflow`=1.
  - Raise CTS → exactly 8 entries delivered in order on 8 consecutive cycles.
- Done ordering: CTS=0; push 2 entries, pulse `src_exchange_done`; `dst_exchange_done` stays 0.
  - Raise CTS → 2 deliveries, then `dst_exchange_done`=1 the cycle after the last one.
  - Writes in DONE set `overflow`.
  - `cycle_done` → next cycle STREAM, `dst_exchange_done`=0, `overflow`=0.
- Mid-drain reset: 4 entries buffered in DRAIN, pulse `reset_n`=0 → next cycle count 0, `dst_exchange_done`=0, no further deliveries.
- Stats (macro defined): 5 deliveries, then `cycle_done` → `transfer_count`=5 and remains 5.
